// File: rtl/spi_cmd_dispatcher.sv
// Command dispatcher: queues decoded SPI packets and executes them one at a time
// against the tile buffer, the NPU core op port and the status register.
module spi_cmd_dispatcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [7:0]        cmd,
  input  logic [2:0]        tile_i,
  input  logic [2:0]        tile_j,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_we,
  output logic              mem_re,
  output logic [5:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [2:0]        op_code_o,
  output logic [5:0]        op_tile,
  output logic [1:0]        dbg_state_o
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENTRY_W = 8 + 3 + 3 + 3 + DATA_W;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_EXEC   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h04;

  typedef enum logic [1:0] {IDLE, DECODE, RD_WAIT, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]          count_q, count_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [2:0]          ti_q, ti_d, tj_q, tj_d, op_q, op_d;
  logic [DATA_W-1:0]   din_q, din_d, dout_q, dout_d;
  logic                ovf_q, ovf_d, bad_q, bad_d;

  logic                fifo_full, fifo_empty, push, pop;
  logic                ovf_set, bad_set, sticky_clr;
  logic [7:0]          h_cmd;
  logic [2:0]          h_ti, h_tj, h_op;
  logic [DATA_W-1:0]   h_din;
  logic [DATA_W-1:0]   status_byte;

  assign fifo_full  = (count_q == 3'(FIFO_DEPTH));
  assign fifo_empty = (count_q == 3'd0);
  assign pop        = (state_q == IDLE) && !fifo_empty;
  // A full FIFO still accepts a packet when the head leaves in the same cycle.
  assign push       = valid && (!fifo_full || pop);
  assign ovf_set    = valid && fifo_full && !pop;

  assign {h_cmd, h_ti, h_tj, h_op, h_din} = fifo_mem[rd_ptr_q];

  assign status_byte = {ovf_q, bad_q, (state_q == ISSUE), 2'b00, count_q};

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd, tile_i, tile_j, op_code, data_in};
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
  end

  // op_valid/op_ready: op_valid rises in ISSUE and holds with op_code_o and
  // op_tile stable until the cycle op_ready is seen high; transfer on both high.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    ti_d       = ti_q;
    tj_d       = tj_q;
    op_d       = op_q;
    din_d      = din_q;
    dout_d     = dout_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    op_valid   = 1'b0;
    bad_set    = 1'b0;
    sticky_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          cmd_d   = h_cmd;
          ti_d    = h_ti;
          tj_d    = h_tj;
          op_d    = h_op;
          din_d   = h_din;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        case (cmd_q)
          CMD_WRITE:  mem_we = 1'b1;
          CMD_READ: begin
            mem_re  = 1'b1;
            state_d = RD_WAIT;
          end
          CMD_EXEC:   state_d = ISSUE;
          CMD_STATUS: begin
            dout_d     = status_byte;
            sticky_clr = 1'b1;
          end
          default:    bad_set = 1'b1;
        endcase
      end
      RD_WAIT: begin
        dout_d  = mem_rdata;
        state_d = IDLE;
      end
      ISSUE: begin
        op_valid = 1'b1;
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A sticky set in the same cycle as a STATUS clear stays set.
    ovf_d = ovf_set ? 1'b1 : (sticky_clr ? 1'b0 : ovf_q);
    bad_d = bad_set ? 1'b1 : (sticky_clr ? 1'b0 : bad_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cmd_q    <= '0;
      ti_q     <= '0;
      tj_q     <= '0;
      op_q     <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cmd_q    <= cmd_d;
      ti_q     <= ti_d;
      tj_q     <= tj_d;
      op_q     <= op_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
    end
  end

  assign data_out    = dout_q;
  assign mem_addr    = {ti_q, tj_q};
  assign mem_wdata   = din_q;
  assign op_code_o   = op_q;
  assign op_tile     = {ti_q, tj_q};
  assign dbg_state_o = state_q;

endmodule
